// File: rtl/pattern_hflipper_pkg.sv
// Shared GPU pattern-line definitions and the pixel-order reversal used by the
// background and sprite paths.
package pattern_hflipper_pkg;

   localparam int unsigned PATTERN_PIXELS = 8;
   localparam int unsigned PATTERN_BPP    = 2;
   localparam int unsigned PATTERN_W      = PATTERN_PIXELS * PATTERN_BPP;

   typedef logic [PATTERN_W-1:0] pattern_line_t;

   // Moves each BPP-bit pixel as a unit; bits inside a pixel keep their order.
   function automatic pattern_line_t pixel_reverse(input pattern_line_t line);
      pattern_line_t rev;
      rev = '0;
      for (int unsigned k = 0; k < PATTERN_PIXELS; k++) begin
         rev[PATTERN_W-1-k*PATTERN_BPP -: PATTERN_BPP] =
            line[PATTERN_W-1-(PATTERN_PIXELS-1-k)*PATTERN_BPP -: PATTERN_BPP];
      end
      return rev;
   endfunction

endpackage

// File: rtl/pattern_hflipper.sv
// Conditionally mirrors one pattern line horizontally (pixel order reversed,
// pixel contents intact), with an optional one-cycle output register.
module pattern_hflipper
   import pattern_hflipper_pkg::*;
#(
   parameter int unsigned PIXELS     = PATTERN_PIXELS,
   parameter int unsigned BPP        = PATTERN_BPP,
   parameter bit          REGISTERED = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PIXELS*BPP-1:0] line_in,
   input  logic                  hflip,
   output logic [PIXELS*BPP-1:0] line_out
);

   localparam int unsigned W = PIXELS * BPP;

   logic [W-1:0] mirrored;
   logic [W-1:0] flipped;
   logic [W-1:0] line_q;

   for (genvar k = 0; k < PIXELS; k++) begin : g_pix
      assign mirrored[W-1-k*BPP -: BPP] = line_in[W-1-(PIXELS-1-k)*BPP -: BPP];
   end

   assign flipped = hflip ? mirrored : line_in;

   // The stage is always described; with REGISTERED=0 it is unobservable and
   // synthesis removes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q <= '0;
      end else begin
         line_q <= flipped;
      end
   end

   always_comb begin
      line_out = flipped;
      if (REGISTERED) begin
         line_out = line_q;
      end
   end

endmodule

// File: tb/tb_pattern_hflipper.sv
// Self-checking bench for pattern_hflipper: directed table, exhaustive sweep,
// PIXELS=1 case and the registered-output reset/latency sequences.
module tb_pattern_hflipper;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] line_in = '0;
   logic        hflip = 1'b0;
   logic [15:0] out_c;
   logic [15:0] out_c2;
   logic [15:0] out_r;
   logic [1:0]  p1_in = '0;
   logic [1:0]  out_p1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pattern_hflipper #(.PIXELS(8), .BPP(2), .REGISTERED(1'b0)) dut_c (
      .clk(clk), .rst(rst), .line_in(line_in), .hflip(hflip), .line_out(out_c));

   // Second combinational stage fed by the first: mirroring twice must restore line_in.
   pattern_hflipper #(.PIXELS(8), .BPP(2), .REGISTERED(1'b0)) dut_c2 (
      .clk(clk), .rst(rst), .line_in(out_c), .hflip(hflip), .line_out(out_c2));

   pattern_hflipper #(.PIXELS(8), .BPP(2), .REGISTERED(1'b1)) dut_r (
      .clk(clk), .rst(rst), .line_in(line_in), .hflip(hflip), .line_out(out_r));

   pattern_hflipper #(.PIXELS(1), .BPP(2), .REGISTERED(1'b0)) dut_p1 (
      .clk(clk), .rst(rst), .line_in(p1_in), .hflip(hflip), .line_out(out_p1));

   typedef struct {
      logic [15:0] line;
      logic        flip;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [15:0] ref_flip(input logic [15:0] v, input logic h);
      logic [15:0] r;
      if (!h) return v;
      r = '0;
      for (int p = 0; p < 8; p++) begin
         r[2*p +: 2] = v[15-2*p -: 2];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s line_in=%h hflip=%b got %h expected %h",
                  name, line_in, hflip, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{16'h1231, 1'b0, 16'h1231};
      vecs[1] = '{16'h1231, 1'b1, 16'h4C84};
      vecs[2] = '{16'hCCCC, 1'b1, 16'h3333};
      vecs[3] = '{16'h1BE4, 1'b1, 16'h1BE4};
      vecs[4] = '{16'h0000, 1'b1, 16'h0000};
      vecs[5] = '{16'hFFFF, 1'b1, 16'hFFFF};
      vecs[6] = '{16'hC000, 1'b1, 16'h0003};
      vecs[7] = '{16'h0001, 1'b1, 16'h4000};
      vecs[8] = '{16'h8000, 1'b1, 16'h0002};
      vecs[9] = '{16'h00FF, 1'b1, 16'hFF00};

      // Directed table on the combinational instance.
      for (int i = 0; i < 10; i++) begin
         line_in = vecs[i].line;
         hflip   = vecs[i].flip;
         #1;
         check("table", out_c, vecs[i].exp);
      end

      // Exhaustive sweep against the reference model, plus double-mirror identity.
      for (int v = 0; v < 65536; v++) begin
         for (int h = 0; h < 2; h++) begin
            line_in = 16'(v);
            hflip   = 1'(h);
            #1;
            check("exhaustive", out_c, ref_flip(16'(v), 1'(h)));
            check("double_mirror", out_c2, 16'(v));
         end
      end

      // PIXELS=1: output equals input regardless of hflip.
      for (int v = 0; v < 4; v++) begin
         for (int h = 0; h < 2; h++) begin
            p1_in = 2'(v);
            hflip = 1'(h);
            #1;
            check("pixels1", {14'h0, out_p1}, 16'(v));
         end
      end

      // Registered instance: load a non-zero value, then assert rst away from any edge.
      @(negedge clk);
      line_in = 16'hFFFF;
      hflip   = 1'b0;
      @(negedge clk);
      check("reg_preload", out_r, 16'hFFFF);
      #2;
      rst = 1'b1;
      #1;
      check("reg_async_rst", out_r, 16'h0000);
      repeat (2) @(negedge clk);
      check("reg_hold_rst", out_r, 16'h0000);

      // Release reset and verify exactly one edge of latency.
      rst     = 1'b0;
      line_in = 16'h1231;
      hflip   = 1'b1;
      #1;
      check("reg_before_edge", out_r, 16'h0000);
      @(posedge clk);
      #1;
      check("reg_one_edge", out_r, 16'h4C84);

      // Back-to-back line accepted the following cycle.
      @(negedge clk);
      line_in = 16'hCCCC;
      #1;
      check("reg_hold_prev", out_r, 16'h4C84);
      @(posedge clk);
      #1;
      check("reg_next_line", out_r, 16'h3333);

      // Mid-stream reset discards the line in flight.
      @(negedge clk);
      line_in = 16'h1BE4;
      hflip   = 1'b0;
      rst     = 1'b1;
      #1;
      check("reg_mid_rst", out_r, 16'h0000);
      @(posedge clk);
      #1;
      check("reg_mid_rst_edge", out_r, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Combinational instance ignores clk and rst.
      line_in = 16'h1231;
      hflip   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rst = ~rst;
         @(posedge clk);
         #1;
         check("comb_ignores_clk_rst", out_c, 16'h4C84);
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
